arb_merge_4_1: RTL and testbench

//  Round-robin merge of four valid/ready input channels onto one registered output channel.

---
 rtl/arb_merge_4_1.sv | 98 +++++++++
 tb/tb_arb_merge_4_1.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/arb_merge_4_1.sv
// Round-robin merge of four valid/ready channels into one registered output stage.
// The grant index drives the 4:1 data mux and is recorded in out_src.
module arb_merge_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src
);

  // Handshake: a word moves on a channel when its valid and ready are both 1
  // at posedge; in_ready is at most one-hot and never asserted during reset.

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;
  logic [1:0]       ptr_q, ptr_d;

  logic             load_en;
  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic             found;
  logic [1:0]       cand;
  logic [WIDTH-1:0] mux_data;

  assign load_en = !out_valid_q || out_ready;

  // Search starts at ptr and wraps; the first requester wins.
  always_comb begin
    grant_idx = 2'd0;
    found     = 1'b0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && in_valid[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end

  assign grant_vld = load_en && found && !rst;
  assign in_ready  = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    case (grant_idx)
      2'd1:    mux_data = in_data1;
      2'd2:    mux_data = in_data2;
      2'd3:    mux_data = in_data3;
      default: mux_data = in_data0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (grant_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = mux_data;
        out_src_d   = grant_idx;
        ptr_d       = grant_idx + 2'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
      ptr_q       <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_merge_4_1.sv
// Directed bench for arb_merge_4_1: reset, single grant, round-robin streaming,
// backpressure hold, pointer wrap and mid-operation reset.
module tb_arb_merge_4_1;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_q[$];
  logic [5:0] exp_w;

  arb_merge_4_1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- driver / checker tasks ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] src,
                           input logic [WIDTH-1:0] data);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'(v));
    check_eq({tag, "_src"},   32'(out_src),   32'(src));
    check_eq({tag, "_data"},  32'(out_data),  32'(data));
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    in_data0 = 4'h0; in_data1 = 4'h0; in_data2 = 4'h0; in_data3 = 4'h0;

    // 1. reset with all requests and downstream ready
    settle();
    check_eq("rst_in_ready_a", 32'(in_ready), 32'h0);
    step();
    check_eq("rst_in_ready_b", 32'(in_ready), 32'h0);
    step();
    check_out("rst", 1'b0, 2'd0, 4'h0);

    // 2. single request on channel 2
    rst = 1'b0; in_valid = 4'b0100; in_data2 = 4'hA;
    settle();
    check_eq("single_ready", 32'(in_ready), 32'b0100);
    step();
    check_out("single", 1'b1, 2'd2, 4'hA);

    // 5. ptr=3: channels 0 and 1 requesting -> wrap to 0, then 1
    in_valid = 4'b0011; in_data0 = 4'h6; in_data1 = 4'h7;
    settle();
    check_eq("wrap_ready0", 32'(in_ready), 32'b0001);
    step();
    check_out("wrap0", 1'b1, 2'd0, 4'h6);
    check_eq("wrap_ready1", 32'(in_ready), 32'b0010);
    step();
    check_out("wrap1", 1'b1, 2'd1, 4'h7);

    // drain: no input valid -> output empties
    in_valid = 4'b0000;
    step();
    check_eq("drain_valid", 32'(out_valid), 32'h0);

    // ptr=2 now; grant channel 3 to bring ptr back to 0
    in_valid = 4'b1000; in_data3 = 4'h9;
    step();
    check_out("to_ptr0", 1'b1, 2'd3, 4'h9);
    in_valid = 4'b0000;
    step();

    // 3. all channels requesting: 0,1,2,3,0 with no bubble
    in_data0 = 4'h1; in_data1 = 4'h2; in_data2 = 4'h3; in_data3 = 4'h4;
    in_valid = 4'hF;
    exp_q.push_back({2'd0, 4'h1});
    exp_q.push_back({2'd1, 4'h2});
    exp_q.push_back({2'd2, 4'h3});
    exp_q.push_back({2'd3, 4'h4});
    exp_q.push_back({2'd0, 4'h1});
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      settle();
      check_eq("rr_ready", 32'(in_ready), 32'(4'b0001 << exp_w[5:4]));
      step();
      check_out("rr", 1'b1, exp_w[5:4], exp_w[3:0]);
    end

    // 4. load 5 from channel 1 (ptr=1), then backpressure for 5 cycles
    in_data1 = 4'h5;
    step();
    check_out("bp_load", 1'b1, 2'd1, 4'h5);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_eq("bp_ready", 32'(in_ready), 32'h0);
      step();
      check_out("bp_hold", 1'b1, 2'd1, 4'h5);
    end
    out_ready = 1'b1;
    settle();
    check_eq("bp_release_ready", 32'(in_ready), 32'b0100);
    step();
    check_out("bp_release", 1'b1, 2'd2, 4'h3);

    // 6. reset while a word is held; ptr was 3 before reset
    out_ready = 1'b0; in_valid = 4'b1010;
    step();
    check_out("pre_rst_hold", 1'b1, 2'd2, 4'h3);
    rst = 1'b1; out_ready = 1'b1;
    settle();
    check_eq("mid_rst_ready", 32'(in_ready), 32'h0);
    step();
    check_out("mid_rst", 1'b0, 2'd0, 4'h0);
    rst = 1'b0;
    settle();
    check_eq("post_rst_ready", 32'(in_ready), 32'b0010);
    step();
    check_out("post_rst", 1'b1, 2'd1, 4'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
